// File: rtl/systolic_pkg.sv
// systolic_pkg: shared FSM state encoding and counter-width helpers for the systolic array scheduler.
package systolic_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, MULT, DRAIN, DONE} state_t;
  function automatic int phase_w(input int vec_w, input int rows, input int cols, input int stage);
    return $clog2(((1 << vec_w) + rows + cols) * stage + 1);
  endfunction
  function automatic int stage_w(input int stage);
    return stage > 1 ? $clog2(stage) : 1;
  endfunction
endpackage

// File: rtl/sched_phase_counter.sv
// sched_phase_counter: en-gated down-counter with load value, zero flag and its next value exposed.
module sched_phase_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] nxt,
  output logic         zero
);
  logic [W-1:0] cnt;
  assign nxt  = load ? load_val : dec ? cnt - W'(1) : cnt;
  assign zero = cnt == '0;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (en) cnt <= nxt;
endmodule

// File: rtl/systolic_scheduler.sv
// systolic_scheduler: sequences weight load, skewed per-row multiply enables and drain for one job.
module systolic_scheduler
  import systolic_pkg::*;
#(
  parameter int ROWS  = 2,
  parameter int COLS  = 2,
  parameter int STAGE = 4,
  parameter int VEC_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             start,
  input  logic [VEC_W-1:0] num_vecs,
  output logic [ROWS-1:0]  load_weight,
  output logic [ROWS-1:0]  enable_mult,
  output logic             load_done,
  output logic             busy,
  output logic             done
);
  localparam int PW = phase_w(VEC_W, ROWS, COLS, STAGE);
  localparam int SW = stage_w(STAGE);
  state_t st, st_n;
  logic [VEC_W-1:0] nv;
  logic pc_ld, pc_dec, pc_zero, sc_ld, sc_dec, sc_zero;
  logic [PW-1:0] pc_val, pc_nxt, base, step;
  logic [SW-1:0] sc_nxt_unused;
  logic [ROWS-1:0] em_n;
  sched_phase_counter #(.W(PW)) u_phase (
    .clk(clk), .reset_n(reset_n), .en(en), .load(pc_ld), .dec(pc_dec),
    .load_val(pc_val), .nxt(pc_nxt), .zero(pc_zero)
  );
  sched_phase_counter #(.W(SW)) u_stage (
    .clk(clk), .reset_n(reset_n), .en(en), .load(sc_ld), .dec(sc_dec),
    .load_val(SW'(STAGE - 1)), .nxt(sc_nxt_unused), .zero(sc_zero)
  );
  // The phase counter counts cycles in LOAD and STAGE-long steps in MULT/DRAIN.
  assign base = PW'(nv) + PW'(ROWS - 1) - PW'(1);
  always_comb begin
    st_n   = st;
    pc_ld  = 1'b0;
    pc_dec = 1'b0;
    sc_ld  = 1'b0;
    sc_dec = 1'b0;
    pc_val = PW'(ROWS - 1);
    case (st)
      IDLE: begin
        st_n  = start ? LOAD : IDLE;
        pc_ld = start;
      end
      LOAD: begin
        st_n   = !pc_zero ? LOAD : nv == '0 ? DONE : MULT;
        pc_dec = !pc_zero;
        pc_ld  = pc_zero;
        sc_ld  = pc_zero;
        pc_val = base;
      end
      MULT, DRAIN: begin
        sc_dec = !sc_zero;
        sc_ld  = sc_zero;
        pc_dec = sc_zero && !pc_zero;
        pc_ld  = sc_zero && pc_zero && st == MULT && COLS > 1;
        pc_val = PW'(COLS > 1 ? COLS - 2 : 0);
        st_n   = !(sc_zero && pc_zero) ? st : (st == MULT && COLS > 1) ? DRAIN : DONE;
      end
      default: st_n = IDLE;
    endcase
    step = base - pc_nxt;
    em_n = '0;
    for (int r = 0; r < ROWS; r++)
      em_n[r] = st_n == MULT && step >= PW'(ROWS - 1 - r) && step < PW'(ROWS - 1 - r) + PW'(nv);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      st          <= IDLE;
      nv          <= '0;
      load_weight <= '0;
      enable_mult <= '0;
      load_done   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else if (en) begin
      st          <= st_n;
      if (st == IDLE && start) nv <= num_vecs;
      load_weight <= st_n == LOAD ? ROWS'(1) << (PW'(ROWS - 1) - pc_nxt) : '0;
      enable_mult <= em_n;
      load_done   <= st_n inside {MULT, DRAIN, DONE};
      busy        <= st_n != IDLE;
      done        <= st_n == DONE;
    end
endmodule

// File: tb/tb_systolic_scheduler.sv
// tb_systolic_scheduler: cycle-index model of two scheduler configurations plus literal timing checks.
module tb_systolic_scheduler;
  logic clk = 1'b0, reset_n, en, start;
  logic [7:0] num_vecs;
  logic [1:0] lw_a, em_a;
  logic [3:0] lw_b, em_b;
  logic ld_a, busy_a, done_a, ld_b, busy_b, done_b;
  int checks = 0, errors = 0;
  bit act [2];
  int t [2];
  int nvm [2];
  localparam logic [3:0] PAT [6] = '{4'b1000, 4'b1100, 4'b1110, 4'b0111, 4'b0011, 4'b0001};

  always #5 clk = ~clk;

  systolic_scheduler #(.ROWS(2), .COLS(2), .STAGE(4), .VEC_W(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .en(en), .start(start), .num_vecs(num_vecs),
    .load_weight(lw_a), .enable_mult(em_a), .load_done(ld_a), .busy(busy_a), .done(done_a)
  );
  systolic_scheduler #(.ROWS(4), .COLS(3), .STAGE(1), .VEC_W(8)) dut_b (
    .clk(clk), .reset_n(reset_n), .en(en), .start(start), .num_vecs(num_vecs),
    .load_weight(lw_b), .enable_mult(em_b), .load_done(ld_b), .busy(busy_b), .done(done_b)
  );

  task automatic chk(input string nm, input logic [7:0] a, input logic [7:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, a, e);
    end
  endtask

  function automatic int total(input int i);
    int r_ = i ? 4 : 2;
    int c_ = i ? 3 : 2;
    int s_ = i ? 1 : 4;
    return nvm[i] == 0 ? r_ + 1 : r_ + (nvm[i] + r_ - 1) * s_ + (c_ - 1) * s_ + 1;
  endfunction

  function automatic void model_out(input int i, output logic [7:0] lw, output logic [7:0] em,
                                    output logic ld, output logic bz, output logic dn);
    int r_ = i ? 4 : 2;
    int s_ = i ? 1 : 4;
    int n = nvm[i];
    int tt = t[i];
    int ll = (n + r_ - 1) * s_;
    int m = tt - r_ - 1;
    lw = '0; em = '0; ld = 1'b0; bz = 1'b0; dn = 1'b0;
    if (act[i]) begin
      bz = 1'b1;
      if (tt <= r_) lw = 8'(1 << (tt - 1));
      else ld = 1'b1;
      if (n > 0 && tt > r_ && tt <= r_ + ll)
        for (int r = 0; r < r_; r++)
          em[r] = m >= (r_ - 1 - r) * s_ && m < (r_ - 1 - r + n) * s_;
      dn = tt == total(i);
    end
  endfunction

  always @(posedge clk) begin
    logic [7:0] elw, eem;
    logic eld, ebz, edn;
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) act[i] = 1'b0;
      else if (en) begin
        if (!act[i]) begin
          if (start) begin act[i] = 1'b1; t[i] = 1; nvm[i] = int'(num_vecs); end
        end else if (t[i] == total(i)) act[i] = 1'b0;
        else t[i]++;
      end
    end
    #1;
    model_out(0, elw, eem, eld, ebz, edn);
    chk("lw_a", 8'(lw_a), elw); chk("em_a", 8'(em_a), eem);
    chk("ld_a", 8'(ld_a), 8'(eld)); chk("busy_a", 8'(busy_a), 8'(ebz)); chk("done_a", 8'(done_a), 8'(edn));
    model_out(1, elw, eem, eld, ebz, edn);
    chk("lw_b", 8'(lw_b), elw); chk("em_b", 8'(em_b), eem);
    chk("ld_b", 8'(ld_b), 8'(eld)); chk("busy_b", 8'(busy_b), 8'(ebz)); chk("done_b", 8'(done_b), 8'(edn));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic launch(input logic [7:0] nv);
    @(negedge clk);
    start = 1'b1;
    num_vecs = nv;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic std_a();
    chk("c1_lw", 8'(lw_a), 8'h01); cyc(1);
    chk("c2_lw", 8'(lw_a), 8'h02); chk("c2_ld", 8'(ld_a), 8'h00); cyc(1);
    chk("c3_em", 8'(em_a), 8'h02); chk("c3_lw", 8'(lw_a), 8'h00); chk("c3_ld", 8'(ld_a), 8'h01); cyc(4);
    chk("c7_em", 8'(em_a), 8'h03); cyc(4);
    chk("c11_em", 8'(em_a), 8'h01); cyc(4);
    chk("c15_em", 8'(em_a), 8'h00); chk("c15_busy", 8'(busy_a), 8'h01); cyc(3);
    chk("c18_done", 8'(done_a), 8'h00); cyc(1);
    chk("c19_done", 8'(done_a), 8'h01); cyc(1);
    chk("c20_busy", 8'(busy_a), 8'h00); chk("c20_ld", 8'(ld_a), 8'h00);
  endtask

  initial begin
    reset_n = 1'b0; en = 1'b1; start = 1'b0; num_vecs = '0;
    cyc(3);
    chk("rst_lw", 8'(lw_a), 8'h00); chk("rst_em", 8'(em_a), 8'h00);
    chk("rst_busy", 8'(busy_a), 8'h00); chk("rst_done", 8'(done_a), 8'h00); chk("rst_ld", 8'(ld_a), 8'h00);
    reset_n = 1'b1;
    cyc(2);
    launch(8'd2); std_a(); cyc(3);
    launch(8'd0);
    chk("z1_lw", 8'(lw_a), 8'h01); cyc(1);
    chk("z2_lw", 8'(lw_a), 8'h02); cyc(1);
    chk("z3_done", 8'(done_a), 8'h01); chk("z3_ld", 8'(ld_a), 8'h01); chk("z3_em", 8'(em_a), 8'h00); cyc(1);
    chk("z4_busy", 8'(busy_a), 8'h00); cyc(3);
    launch(8'd2); cyc(4);
    chk("f5_em", 8'(em_a), 8'h02);
    en = 1'b0; cyc(5);
    chk("frz_em", 8'(em_a), 8'h02); chk("frz_busy", 8'(busy_a), 8'h01);
    en = 1'b1; cyc(13);
    chk("f18_done", 8'(done_a), 8'h00); cyc(1);
    chk("f19_done", 8'(done_a), 8'h01); cyc(3);
    launch(8'd2); cyc(5);
    reset_n = 1'b0;
    #1;
    chk("ar_lw", 8'(lw_a), 8'h00); chk("ar_em", 8'(em_a), 8'h00); chk("ar_busy", 8'(busy_a), 8'h00);
    chk("ar_ld", 8'(ld_a), 8'h00); chk("ar_done", 8'(done_a), 8'h00); chk("ar_busy_b", 8'(busy_b), 8'h00);
    cyc(2); reset_n = 1'b1; cyc(2);
    launch(8'd2); std_a(); cyc(3);
    @(negedge clk);
    start = 1'b1; num_vecs = 8'd2;
    cyc(1);
    chk("h1_busy", 8'(busy_a), 8'h01); cyc(18);
    chk("h19_done", 8'(done_a), 8'h01); cyc(1);
    chk("h20_busy", 8'(busy_a), 8'h00); cyc(1);
    chk("h21_busy", 8'(busy_a), 8'h01); chk("h21_lw", 8'(lw_a), 8'h01);
    start = 1'b0; cyc(25);
    launch(8'd3);
    for (int k = 0; k < 4; k++) begin chk("b_lw", 8'(lw_b), 8'(1 << k)); cyc(1); end
    for (int k = 0; k < 6; k++) begin chk("b_em", 8'(em_b), 8'(PAT[k])); cyc(1); end
    chk("b11_em", 8'(em_b), 8'h00); chk("b11_busy", 8'(busy_b), 8'h01); cyc(1);
    chk("b12_em", 8'(em_b), 8'h00); chk("b12_done", 8'(done_b), 8'h00); cyc(1);
    chk("b13_done", 8'(done_b), 8'h01); cyc(1);
    chk("b14_busy", 8'(busy_b), 8'h00); cyc(12);
    en = 1'b0; start = 1'b1; cyc(2);
    chk("ign_busy_a", 8'(busy_a), 8'h00); chk("ign_busy_b", 8'(busy_b), 8'h00);
    start = 1'b0; en = 1'b1; cyc(2);
    chk("ign2_busy_a", 8'(busy_a), 8'h00);
    launch(8'd255); cyc(1029);
    chk("max_done0", 8'(done_a), 8'h00); cyc(1);
    chk("max_done1", 8'(done_a), 8'h01); cyc(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/systolic_scheduler.md
SYSTOLIC_SCHEDULER -- requirements
Module: systolic_scheduler

Interface
REQ-001 Parameter ROWS, default 2: number of PE rows; must be >= 1.
REQ-002 Parameter COLS, default 2: number of PE columns; sets the drain length; must be >= 1.
REQ-003 Parameter STAGE, default 4: cycles per PE pipeline stage (the skew step); must be >= 1.
REQ-004 Parameter VEC_W, default 8: width of num_vecs.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 en  input  1  global enable; low freezes all state and holds outputs.
REQ-008 start  input  1  request one load+multiply job; sampled only when en=1.
REQ-009 num_vecs  input  VEC_W  number of input vectors streamed per job; captured on start acceptance.
REQ-010 load_weight  output  ROWS  one-hot weight-load strobe, bit i loads row i.
REQ-011 enable_mult  output  ROWS  per-row multiply enable, skewed by STAGE cycles.
REQ-012 load_done  output  1  high from the end of the load phase until the job ends.
REQ-013 busy  output  1  high while a job is in progress (state not IDLE).
REQ-014 done  output  1  one-cycle completion pulse.

Function
REQ-015 All outputs shall be registered; no combinational path from any input to any output.
REQ-016 The FSM shall have the states IDLE, LOAD, MULT, DRAIN and DONE.
REQ-017 In IDLE with en=1 and start=1, the block shall capture num_vecs and enter LOAD on that edge (edge T0).
REQ-018 start in any non-IDLE state, or with en=0, shall be ignored without side effects.
REQ-019 LOAD shall last ROWS cycles; in LOAD cycle k (k=0..ROWS-1), load_weight shall equal 1<<k.
REQ-020 On leaving LOAD, load_weight shall return to zero and load_done shall assert.
REQ-021 If the captured num_vecs=0, LOAD shall go directly to DONE, with no MULT/DRAIN and enable_mult staying zero.
REQ-022 MULT shall last (num_vecs+ROWS-1)*STAGE cycles.
REQ-023 Row ROWS-1-j shall assert at MULT cycle j*STAGE and stay high for exactly num_vecs*STAGE cycles, then deassert.
REQ-024 DRAIN shall last (COLS-1)*STAGE cycles with enable_mult all zero; COLS=1 shall skip DRAIN.
REQ-025 DONE shall last one cycle: done=1, busy=1; then IDLE, with load_done and busy cleared.
REQ-026 A start arriving during the DONE cycle shall be ignored; a new job needs start while in IDLE.
REQ-027 With en=0, state, counters and all outputs shall hold their values (done may stretch); a phase resumes where it stopped.
REQ-028 Phase counters shall be wide enough for (2^VEC_W-1+ROWS-1)*STAGE with no wrap-around.

Reset
REQ-029 reset_n low shall immediately force IDLE, clear all counters, and drive load_weight=0, enable_mult=0, load_done=0, busy=0, done=0.
REQ-030 A reset_n assertion mid-job shall abort the job with no done pulse; operation after release shall restart from IDLE.
REQ-031 Reset release shall take effect synchronously to clk, with no job started on the release edge unless start=1 and en=1.

Structure
REQ-032 Package systolic_pkg shall hold the FSM state enum and the counter-width constant functions, shared with the array top level.
REQ-033 One sub-module, sched_phase_counter, shall be used: an en-gated down-counter with load value and zero flag, instanced for the phase and stage counts.

Verification
REQ-034 ROWS=COLS=2, STAGE=4, num_vecs=2, start at T0 -> load_weight 01,10 in cycles 1-2; MULT cycles 3-14; enable_mult=10 cycles 3-10 and 01 cycles 7-14; DRAIN 15-18; done at cycle 19 only.
REQ-035 Same configuration, num_vecs=0 -> LOAD cycles 1-2, done at cycle 3, enable_mult never nonzero.
REQ-036 en held low 5 cycles inside MULT -> every output frozen for those cycles; done 5 cycles later than REQ-034.
REQ-037 reset_n pulsed low at cycle 6 of a job -> all outputs 0 asynchronously, no done; a fresh start afterwards repeats the REQ-034 timing.
REQ-038 start held high throughout a job -> exactly one job runs; the second job begins only after returning to IDLE.
REQ-039 ROWS=4, COLS=3, STAGE=1, num_vecs=3 -> MULT 6 cycles with the row enable pattern 1000,1100,1110,0111,0011,0001; DRAIN 2 cycles; then done.
